// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Purpose:
//   General-purpose register file with 2**ADDR_W registers of DATA_W bits each.
//   It has one synchronous write port and two independent combinational read
//   ports. Register 0 is hardwired to zero. An asynchronous active-low reset
//   clears every register.
//
// Configuration:
//   REGFILE_BYPASS_EN - When this macro is defined, a read that hits the
//                       register being written in the same cycle returns WD
//                       (write-through). Register 0 is never forwarded.
//                       When the macro is undefined, a read returns the stored
//                       value until the clock edge.
//
// Parameters:
//   DATA_W   - register / data port width in bits (default 32)
//   ADDR_W   - address width; register count is 2**ADDR_W (default 6)
//
// Ports:
//   clk      in   1       clock, writes on rising edge
//   rst_n    in   1       asynchronous active-low reset
//   R1       in   ADDR_W  read address, port 1
//   R2       in   ADDR_W  read address, port 2
//   WR       in   ADDR_W  write address
//   WD       in   DATA_W  write data
//   RegWrite in   1       write enable, active-high
//   RD1      out  DATA_W  read data, port 1
//   RD2      out  DATA_W  read data, port 2
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  input  logic [ADDR_W-1:0] WR,
  input  logic [DATA_W-1:0] WD,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic w_wrValid;
  logic [DATA_W-1:0] w_rd1Stored;
  logic [DATA_W-1:0] w_rd2Stored;

  // Writes to address 0 are dropped here. Entry 0 therefore stays at its reset
  // value of zero, and the read path also forces 0 for address 0.
  assign w_wrValid = RegWrite && (WR != '0);

  // Register array. The reset clears every entry at once. Reset takes priority
  // over a write that lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrValid) begin
      r_regs[WR] <= WD;
    end
  end

  assign w_rd1Stored = (R1 == '0) ? '0 : r_regs[R1];
  assign w_rd2Stored = (R2 == '0) ? '0 : r_regs[R2];

`ifdef REGFILE_BYPASS_EN
  // Write-through forwarding. w_wrValid already excludes address 0, so
  // register 0 can never be forwarded.
  always_comb begin
    RD1 = w_rd1Stored;
    RD2 = w_rd2Stored;
    if (w_wrValid && (R1 == WR)) begin
      RD1 = WD;
    end
    if (w_wrValid && (R2 == WR)) begin
      RD2 = WD;
    end
  end
`else
  always_comb begin
    RD1 = w_rd1Stored;
    RD2 = w_rd2Stored;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Purpose:
//   Directed testbench for register_file. It applies hand-computed vectors.
//   Each scenario task compares the DUT outputs against expected values and
//   prints a FAIL line on mismatch. The bench ends with a single summary line.
//   The bypass-dependent expectations follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] R1, R2, WR;
  logic [DATA_W-1:0] WD;
  logic              RegWrite;
  logic [DATA_W-1:0] RD1, RD2;

  int checks = 0;
  int errors = 0;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .R1(R1), .R2(R2), .WR(WR), .WD(WD),
    .RegWrite(RegWrite), .RD1(RD1), .RD2(RD2)
  );

  always #5 clk = ~clk;

  // Writes one register on the next rising edge, then drops the enable.
  task automatic doWrite(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    WR = addr; WD = data; RegWrite = 1'b1;
    @(posedge clk);
    #1;
    RegWrite = 1'b0; WD = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; RegWrite = 1'b0; WR = '0; WD = '0; R1 = 6'd5; R2 = 6'd63;
    #12;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd1 got %h expected %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd2 got %h expected %h", RD2, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_r0;
    @(negedge clk);
    WR = 6'd0; WD = 32'h19; RegWrite = 1'b1; R1 = 6'd0; R2 = 6'd0;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("[TB] FAIL r0_no_bypass got %h expected %h", RD1, 32'h0); end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("[TB] FAIL r0_rd1 got %h expected %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("[TB] FAIL r0_rd2 got %h expected %h", RD2, 32'h0); end
  endtask

  task automatic test_write_hold;
    doWrite(6'd1, 32'h24);
    R1 = 6'd0; R2 = 6'd1;
    #1;
    checks++;
    if (RD2 !== 32'h24) begin errors++; $display("[TB] FAIL r1_read got %h expected %h", RD2, 32'h24); end
    WR = 6'd1; WD = 32'h0; RegWrite = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (RD2 !== 32'h24) begin errors++; $display("[TB] FAIL hold_rd2 cycle %0d got %h expected %h", i, RD2, 32'h24); end
      checks++;
      if (RD1 !== 32'h0) begin errors++; $display("[TB] FAIL hold_rd1 cycle %0d got %h expected %h", i, RD1, 32'h0); end
    end
  endtask

  task automatic test_top_reg;
    doWrite(6'd63, 32'hDEADBEEF);
    R1 = 6'd63; R2 = 6'd63;
    #1;
    checks++;
    if (RD1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL r63_rd1 got %h expected %h", RD1, 32'hDEADBEEF); end
    checks++;
    if (RD2 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL r63_rd2 got %h expected %h", RD2, 32'hDEADBEEF); end
    R1 = 6'd62; R2 = 6'd31;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("[TB] FAIL r62_zero got %h expected %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("[TB] FAIL r31_zero got %h expected %h", RD2, 32'h0); end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] vals [4] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003, 32'hF0F0_0004};
    @(negedge clk);
    RegWrite = 1'b1;
    for (int i = 0; i < 4; i++) begin
      WR = 6'(10 + i); WD = vals[i];
      @(negedge clk);
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 4; i += 2) begin
      R1 = 6'(10 + i); R2 = 6'(11 + i);
      #1;
      checks++;
      if (RD1 !== vals[i]) begin errors++; $display("[TB] FAIL b2b_rd1 r%0d got %h expected %h", 10 + i, RD1, vals[i]); end
      checks++;
      if (RD2 !== vals[i+1]) begin errors++; $display("[TB] FAIL b2b_rd2 r%0d got %h expected %h", 11 + i, RD2, vals[i+1]); end
    end
  endtask

  task automatic test_same_addr;
    logic [DATA_W-1:0] expBefore;
`ifdef REGFILE_BYPASS_EN
    expBefore = 32'h22;
`else
    expBefore = 32'h11;
`endif
    doWrite(6'd5, 32'h11);
    @(negedge clk);
    WR = 6'd5; WD = 32'h22; RegWrite = 1'b1; R1 = 6'd5; R2 = 6'd1;
    #1;
    checks++;
    if (RD1 !== expBefore) begin errors++; $display("[TB] FAIL same_addr_before got %h expected %h", RD1, expBefore); end
    checks++;
    if (RD2 !== 32'h24) begin errors++; $display("[TB] FAIL same_addr_other got %h expected %h", RD2, 32'h24); end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    checks++;
    if (RD1 !== 32'h22) begin errors++; $display("[TB] FAIL same_addr_after got %h expected %h", RD1, 32'h22); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    R1 = 6'd63; R2 = 6'd1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_rd1 got %h expected %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_rd2 got %h expected %h", RD2, 32'h0); end
    R1 = 6'd13; R2 = 6'd5;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_r13 got %h expected %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_r5 got %h expected %h", RD2, 32'h0); end
  endtask

  task automatic test_reset_priority;
    @(negedge clk);
    WR = 6'd3; WD = 32'h55; RegWrite = 1'b1;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; R1 = 6'd3; R2 = 6'd3;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("[TB] FAIL rst_priority_r3 got %h expected %h", RD1, 32'h0); end
    doWrite(6'd3, 32'h66);
    checks++;
    if (RD2 !== 32'h66) begin errors++; $display("[TB] FAIL first_write_after_rst got %h expected %h", RD2, 32'h66); end
  endtask

  initial begin
    test_reset;
    test_write_r0;
    test_write_hold;
    test_top_reg;
    test_back_to_back;
    test_same_addr;
    test_async_reset;
    test_reset_priority;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
